// File: rtl/cpu_trace_pkg.sv
// cpu_trace_pkg -- shared constants, serializer state type and beat-slicing
// helper for the CPU trace drain.
// Optional feature macro: TRACE_OVF_MARKER_EN (adds the OVF state).
package cpu_trace_pkg;

    localparam int unsigned PKT_W   = 256;
    localparam int unsigned BEAT_W  = 32;
    localparam int unsigned BEATS   = 8;
    localparam logic [15:0] OVF_TAG = 16'hFFFF;

`ifdef TRACE_OVF_MARKER_EN
    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_OVF} state_e;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SEND} state_e;
`endif

    // Beat k of a packet, MSB first: beat 0 is pkt[255:224].
    function automatic logic [BEAT_W-1:0] beat_of(input logic [PKT_W-1:0] pkt,
                                                  input logic [2:0]       k);
        int unsigned base;
        base = (BEATS - 1 - int'(k)) * BEAT_W;
        return pkt[base +: BEAT_W];
    endfunction

endpackage

// File: rtl/cpu_trace_fifo.sv
// cpu_trace_fifo -- synchronous FIFO holding whole trace packets.
// Ports: clk, srst (sync, active-high), push_i/din_i write side,
//        pop_i read side, dout_o (head entry), full_o, empty_o, level_o.
// With TRACE_OVF_MARKER_EN, mark_i sets the top bit (the overflow flag)
// of the newest stored entry.
module cpu_trace_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 256
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     push_i,
    input  logic [W-1:0]             din_i,
    input  logic                     pop_i,
`ifdef TRACE_OVF_MARKER_EN
    input  logic                     mark_i,
`endif
    output logic [W-1:0]             dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [LW-1:0] cnt_q;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == LW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign level_o = cnt_q;
    assign dout_o  = mem_q[rd_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + LW'(1);
                2'b01:   cnt_q <= cnt_q - LW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
`ifdef TRACE_OVF_MARKER_EN
        // Marking only happens on a drop, i.e. never together with a push,
        // so the newest entry sits just behind the write pointer.
        if (mark_i && !empty_o) mem_q[wr_q - AW'(1)][W-1] <= 1'b1;
`endif
    end

endmodule

// File: rtl/cpu_trace_drain.sv
// cpu_trace_drain -- buffers 256-bit trace packets and serializes each one
// as 8 x 32-bit beats (MSB first) on a valid/ready stream.
// Ports: clk, srst (sync, active-high), enable, pkg_valid, pkg (input packet);
//        out_valid, out_data, out_last, out_ready (beat stream);
//        full, level, drop_cnt (saturating), busy (status).
// Macro TRACE_OVF_MARKER_EN: drops flag the newest buffered packet, and an
// 8-beat marker {OVF_TAG, segment drop count} follows that packet.
module cpu_trace_drain
    import cpu_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   enable,
    input  logic                   pkg_valid,
    input  logic [255:0]           pkg,
    output logic                   out_valid,
    output logic [31:0]            out_data,
    output logic                   out_last,
    input  logic                   out_ready,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level,
    output logic [15:0]            drop_cnt,
    output logic                   busy
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;
`ifdef TRACE_OVF_MARKER_EN
    localparam int unsigned FW = PKT_W + 1;
`else
    localparam int unsigned FW = PKT_W;
`endif

    state_e        state_q, state_d;
    logic [2:0]    beat_q, beat_d;
    logic [15:0]   drop_q, drop_d;
    logic [FW-1:0] head;
    logic          empty, push, drop, fire, last_beat, pop;

    assign push      = pkg_valid & enable & ~full;
    assign drop      = pkg_valid & enable & full;
    assign fire      = out_valid & out_ready;
    assign last_beat = (beat_q == 3'd7);
    assign pop       = (state_q == ST_SEND) & fire & last_beat;

`ifdef TRACE_OVF_MARKER_EN
    logic [15:0] seg_q, seg_d, seg_lat_q;
    logic        enter_ovf;

    assign enter_ovf = pop & head[PKT_W];
`endif

    cpu_trace_fifo #(
        .DEPTH (DEPTH),
        .W     (FW)
    ) u_fifo (
        .clk     (clk),
        .srst    (srst),
        .push_i  (push),
`ifdef TRACE_OVF_MARKER_EN
        .din_i   ({1'b0, pkg}),
        .mark_i  (drop),
`else
        .din_i   (pkg),
`endif
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            drop_q  <= drop_d;
        end
    end

`ifdef TRACE_OVF_MARKER_EN
    always_ff @(posedge clk) begin
        if (srst) begin
            seg_q     <= '0;
            seg_lat_q <= '0;
        end else begin
            seg_q <= seg_d;
            if (enter_ovf) seg_lat_q <= seg_q;
        end
    end

    // Segment restarts on OVF entry; a drop in that same cycle opens it at 1.
    always_comb begin
        seg_d = seg_q;
        if (enter_ovf)                    seg_d = {15'd0, drop};
        else if (drop && seg_q != 16'hFFFF) seg_d = seg_q + 16'd1;
    end
`endif

    always_comb begin
        drop_d = drop_q;
        if (drop && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    state_d = ST_SEND;
                    beat_d  = '0;
                end
            end
            ST_SEND: begin
                if (fire) begin
                    beat_d = beat_q + 3'd1;
                    if (last_beat) begin
                        // Stay in SEND when another packet remains after this
                        // pop (or arrives now) so streaming has no bubble.
                        if (level > LW'(1) || push) state_d = ST_SEND;
                        else                        state_d = ST_IDLE;
`ifdef TRACE_OVF_MARKER_EN
                        if (head[PKT_W]) state_d = ST_OVF;
`endif
                    end
                end
            end
`ifdef TRACE_OVF_MARKER_EN
            ST_OVF: begin
                if (fire) begin
                    beat_d = beat_q + 3'd1;
                    if (last_beat) state_d = (!empty || push) ? ST_SEND : ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                beat_d  = '0;
            end
        endcase
    end

    always_comb begin
        out_valid = (state_q != ST_IDLE);
        out_last  = out_valid & last_beat;
        busy      = ~empty | out_valid;
        out_data  = '0;
        if (state_q == ST_SEND) out_data = beat_of(head[PKT_W-1:0], beat_q);
`ifdef TRACE_OVF_MARKER_EN
        if (state_q == ST_OVF && beat_q == 3'd0) out_data = {OVF_TAG, seg_lat_q};
`endif
    end

    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_cpu_trace_drain.sv
module tb_cpu_trace_drain;

    logic         clk = 1'b0;
    logic         srst;
    logic         enable;
    logic         pkg_valid;
    logic [255:0] pkg;
    logic         out_valid;
    logic [31:0]  out_data;
    logic         out_last;
    logic         out_ready;
    logic         full;
    logic [2:0]   level;
    logic [15:0]  drop_cnt;
    logic         busy;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [31:0] got_q[$];
    logic        lst_q[$];

    cpu_trace_drain #(.DEPTH(4)) dut (
        .clk       (clk),
        .srst      (srst),
        .enable    (enable),
        .pkg_valid (pkg_valid),
        .pkg       (pkg),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .full      (full),
        .level     (level),
        .drop_cnt  (drop_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packet whose beat k is {id, k, 16'hBEEF}.
    function automatic logic [255:0] mk(input logic [7:0] id);
        logic [255:0] p;
        for (int k = 0; k < 8; k++) p[(7-k)*32 +: 32] = {id, 8'(k), 16'hBEEF};
        return p;
    endfunction

    function automatic logic [31:0] bt(input logic [7:0] id, input int k);
        return {id, 8'(k), 16'hBEEF};
    endfunction

    task automatic collect(input int budget);
        got_q.delete();
        lst_q.delete();
        for (int c = 0; c < budget; c++) begin
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                lst_q.push_back(out_last);
            end
            tick();
        end
    endtask

    int n_last;
    int exp_beats;

    initial begin
        srst = 1'b1; enable = 1'b1; pkg_valid = 1'b0; pkg = '0; out_ready = 1'b1;
        tick(); tick();
        srst = 1'b0;

        // Reset state
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_data",  out_data,  0);
        check_eq("rst_full",  full,      0);
        check_eq("rst_level", level,     0);
        check_eq("rst_drop",  drop_cnt,  0);
        check_eq("rst_busy",  busy,      0);

        // Single packet, one-cycle latency, 8 consecutive beats
        pkg_valid = 1'b1;
        pkg = 256'h0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF;
        tick();
        pkg_valid = 1'b0;
        check_eq("lat_level", level, 1);
        check_eq("lat_valid_early", out_valid, 0);
        tick();
        for (int k = 0; k < 8; k++) begin
            check_eq("single_valid", out_valid, 1);
            check_eq("single_data",  out_data, (k % 2 == 0) ? 32'h01234567 : 32'h89ABCDEF);
            check_eq("single_last",  out_last, (k == 7) ? 1 : 0);
            tick();
        end
        check_eq("single_done_valid", out_valid, 0);
        check_eq("single_done_busy",  busy, 0);

        // Backpressure on beat 3
        pkg_valid = 1'b1; pkg = mk(8'h02);
        tick();
        pkg_valid = 1'b0;
        tick();
        for (int k = 0; k < 8; k++) begin
            check_eq("bp_data", out_data, bt(8'h02, k));
            if (k == 3) begin
                out_ready = 1'b0;
                for (int h = 0; h < 5; h++) begin
                    tick();
                    check_eq("bp_hold_valid", out_valid, 1);
                    check_eq("bp_hold_data",  out_data, bt(8'h02, 3));
                    check_eq("bp_hold_last",  out_last, 0);
                end
                out_ready = 1'b1;
            end
            tick();
        end
        check_eq("bp_done_busy", busy, 0);

        // Overflow: 7 pushes into a 4-deep buffer with the sink stalled
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            pkg_valid = 1'b1; pkg = mk(8'(8'h10 + i));
            tick();
        end
        pkg_valid = 1'b0;
        check_eq("ovf_full",  full, 1);
        check_eq("ovf_level", level, 4);
        check_eq("ovf_drop",  drop_cnt, 3);
        out_ready = 1'b1;
        collect(60);
`ifdef TRACE_OVF_MARKER_EN
        exp_beats = 40;
`else
        exp_beats = 32;
`endif
        check_eq("ovf_beats", got_q.size(), exp_beats);
        if (got_q.size() == exp_beats) begin
            for (int i = 0; i < 32; i++)
                check_eq("ovf_beat_data", got_q[i], bt(8'(8'h10 + i / 8), i % 8));
`ifdef TRACE_OVF_MARKER_EN
            check_eq("ovf_marker0", got_q[32], 32'hFFFF0003);
            for (int i = 33; i < 40; i++) check_eq("ovf_marker_zero", got_q[i], 0);
`endif
        end
        n_last = 0;
        foreach (lst_q[i]) if (lst_q[i]) n_last++;
        check_eq("ovf_lasts", n_last, exp_beats / 8);
        check_eq("ovf_drop_after", drop_cnt, 3);
        check_eq("ovf_level_after", level, 0);

        // Reset during beat 5, then an immediate push
        pkg_valid = 1'b1; pkg = mk(8'h20);
        tick();
        pkg_valid = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) tick();
        check_eq("mid_beat5", out_data, bt(8'h20, 5));
        srst = 1'b1;
        tick();
        srst = 1'b0;
        check_eq("mid_valid", out_valid, 0);
        check_eq("mid_level", level, 0);
        check_eq("mid_drop",  drop_cnt, 0);
        check_eq("mid_busy",  busy, 0);
        pkg_valid = 1'b1; pkg = mk(8'h21);
        tick();
        pkg_valid = 1'b0;
        check_eq("post_rst_level", level, 1);
        tick();
        for (int k = 0; k < 8; k++) begin
            check_eq("post_rst_data", out_data, bt(8'h21, k));
            check_eq("post_rst_last", out_last, (k == 7) ? 1 : 0);
            tick();
        end

        // enable=0 ignores offered packets but keeps draining
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pkg_valid = 1'b1; pkg = mk(8'(8'h40 + i));
            tick();
        end
        enable = 1'b0; pkg = mk(8'h99);
        for (int i = 0; i < 10; i++) tick();
        check_eq("dis_level", level, 4);
        check_eq("dis_drop",  drop_cnt, 0);
        out_ready = 1'b1;
        collect(45);
        check_eq("dis_beats", got_q.size(), 32);
        if (got_q.size() == 32) begin
            check_eq("dis_first", got_q[0],  bt(8'h40, 0));
            check_eq("dis_last",  got_q[31], bt(8'h43, 7));
        end
        check_eq("dis_level_after", level, 0);
        check_eq("dis_busy_after",  busy, 0);
        check_eq("dis_drop_after",  drop_cnt, 0);
        pkg_valid = 1'b0; enable = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
